// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and data-memory bus signals of the load/store sequencer.
// slave is the controller's view; master is the view of the pipeline plus memory around it.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_exc, resp_exc_code,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_exc, resp_exc_code,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: checks one MEM-stage request, runs the bus handshake with a
// timeout, and returns extended load data or a MIPS exception code.
//   state | meaning
//   IDLE  | ready for a request
//   REQ   | mem_req high, waiting for mem_gnt
//   WAIT  | granted, waiting for mem_rvalid
//   RESP  | one-cycle completion pulse
module mem_access_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input logic               clk,
  input logic               reset,
  mem_access_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [2:0]       op_q;
  logic [1:0]       lane_q;
  logic [29:0]      word_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic             exc_q;
  logic [4:0]       code_q;
  logic [31:0]      rdata_q;

  logic accept, illegal_op, misaligned, timeout, gnt_evt, rvalid_evt;

  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      3'b000:         byte_en = 4'b1111;
      3'b001, 3'b011: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default:        byte_en = 4'b0001 << lane;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      3'b000:  lane_data = wdata;
      3'b001:  lane_data = {2{wdata[15:0]}};
      default: lane_data = {4{wdata[7:0]}};
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [1:0] lane,
                                         input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'b000:  extend = rdata;
      3'b001:  extend = {{16{h[15]}}, h};
      3'b010:  extend = {{24{b[7]}}, b};
      3'b011:  extend = {16'h0000, h};
      3'b100:  extend = {24'h000000, b};
      default: extend = 32'h0;
    endcase
  endfunction

  assign accept     = (state_q == IDLE) && bus.req_valid;
  assign illegal_op = bus.req_we ? (bus.req_op > 3'd2) : (bus.req_op > 3'd4);
  assign misaligned = ((bus.req_op == 3'b000) && (bus.req_addr[1:0] != 2'b00)) ||
                      (((bus.req_op == 3'b001) || (bus.req_op == 3'b011)) && bus.req_addr[0]);
  // Budget covers REQ+WAIT together; this is the last cycle it allows.
  assign timeout    = cnt_q >= CNT_W'(MAX_WAIT - 1);
  assign gnt_evt    = (state_q == REQ) && bus.mem_gnt;
  assign rvalid_evt = (state_q == WAIT) && bus.mem_rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = (illegal_op || misaligned) ? RESP : REQ;
      REQ:  if (gnt_evt) state_d = WAIT;
            else if (timeout) state_d = RESP;
      WAIT: if (rvalid_evt || timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      op_q    <= 3'b000;
      lane_q  <= 2'b00;
      word_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      exc_q   <= 1'b0;
      code_q  <= 5'd0;
      rdata_q <= 32'h0;
    end else if (accept) begin
      cnt_q   <= '0;
      we_q    <= bus.req_we;
      op_q    <= bus.req_op;
      lane_q  <= bus.req_addr[1:0];
      word_q  <= bus.req_addr[31:2];
      be_q    <= byte_en(bus.req_op, bus.req_addr[1:0]);
      wdata_q <= lane_data(bus.req_op, bus.req_wdata);
      rdata_q <= 32'h0;
      exc_q   <= illegal_op || misaligned;
      if (illegal_op)      code_q <= 5'd10;
      else if (misaligned) code_q <= bus.req_we ? 5'd5 : 5'd4;
      else                 code_q <= 5'd0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (rvalid_evt) begin
        rdata_q <= we_q ? 32'h0 : extend(op_q, lane_q, bus.mem_rdata);
      end else if (timeout && !gnt_evt) begin
        exc_q  <= 1'b1;
        code_q <= 5'd7;
      end
    end
  end

  always_comb begin
    bus.req_ready     = (state_q == IDLE);
    bus.stall         = bus.req_valid && (state_q != RESP);
    bus.resp_valid    = (state_q == RESP);
    bus.resp_exc      = (state_q == RESP) && exc_q;
    bus.resp_exc_code = (state_q == RESP) ? code_q : 5'd0;
    bus.resp_rdata    = (state_q == RESP) ? rdata_q : 32'h0;
    bus.mem_req       = (state_q == REQ);
    bus.mem_we        = we_q;
    bus.mem_addr      = {word_q, 2'b00};
    bus.mem_be        = be_q;
    bus.mem_wdata     = wdata_q;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the MEM pipeline stage and the data-memory bus. It accepts one memory request from the pipeline and checks alignment and op legality. It then drives a word-aligned bus transaction with byte enables and replicated store data, waits for the bus handshake and returns sign/zero-extended load data. It stalls the pipeline for the whole transaction and converts misalignment, illegal ops and bus timeouts into MIPS exception codes.

## Interface
- MAX_WAIT, 255, cycles allowed in REQ+WAIT before timeout; legal range ≥2. Counter width is $clog2(MAX_WAIT+1).
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage holds a memory op
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  000 word, 001 half signed, 010 byte signed, 011 half unsigned, 100 byte unsigned; stores use only 000/001/010
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned
- req_ready  out  1  request accepted this cycle when high with req_valid
- stall  out  1  freeze pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/exceptions)
- resp_exc  out  1  exception on this completion
- resp_exc_code  out  5  4 AdEL, 5 AdES, 7 DBE (timeout), 10 RI (illegal op)
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  bus accepted request
- mem_rvalid  in  1  bus completion (load data valid or store ack)
- mem_rdata  in  32  load word

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/op/addr/wdata and compute checks.
  - Illegal op (store op>010 or load op>100) → RESP with code 10.
  - Else misaligned (word addr[1:0]≠0, half addr[0]≠0) → RESP with code 4 (load) or 5 (store).
  - Else → REQ.
- REQ:
  - mem_req=1; mem_we/addr/be/wdata come from latched registers and are stable until gnt.
  - On mem_gnt → WAIT.
  - mem_rvalid in REQ is ignored.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, capture mem_rdata → RESP, no exception.
- Timeout:
  - The counter clears on accept and increments each cycle in REQ or WAIT.
  - When it reaches MAX_WAIT with no completing event that cycle → RESP with code 7; mem_req drops.
  - A completing event (gnt in REQ, rvalid in WAIT) in the same cycle wins over the timeout.
- RESP:
  - resp_valid=1 for exactly one cycle, req_ready=0 → IDLE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
  - Loads drive the same enables.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extension:
  - Byte lane is rdata[8*addr[1:0]+7 -: 8]; half lane is rdata[16*addr[1]+15 -: 16].
  - Signed ops replicate the lane MSB; unsigned ops zero-fill.
- stall = req_valid & (state≠RESP). The pipeline advances on the RESP edge; the next request is sampled in IDLE.
- mem_rvalid/mem_gnt arriving in IDLE or RESP is ignored.

## Timing
- Reset (asynchronous, reset=0):
  - State → IDLE; counter and all latched registers → 0.
  - mem_req, resp_valid, resp_exc, resp_exc_code, resp_rdata, mem_be, mem_wdata, mem_addr, mem_we = 0.
  - req_ready=1 (requests are not sampled while reset is low); stall = req_valid.
- Reset mid-transaction: the transaction is aborted, mem_req drops immediately, and no response is produced.
- Minimum bus latency:
  - Accept at cycle 0, REQ with gnt at cycle 1, WAIT with rvalid at cycle 2, resp_valid at cycle 3.
- Exception path: resp_valid in the cycle after accept; mem_req is never asserted.
- Outputs are registered/state-decoded; no combinational path from mem_* inputs to mem_* outputs.

## Test plan
- Load byte (op 010) at addr 0x0000_1003, gnt at cycle 1, rvalid at cycle 2 with rdata 0x80FF_1234:
  - mem_addr 0x1000, mem_be 1000.
  - resp_valid at cycle 3 with resp_rdata 0xFFFF_FF80, resp_exc 0.
- Load half unsigned (op 011) at 0x0000_0002, gnt delayed 3 cycles, rdata 0x8001_0000:
  - resp_rdata 0x0000_8001.
  - stall high every cycle until RESP.
- Store half (sh) at 0x0000_0006 with wdata 0x0000_BEEF:
  - mem_we 1, mem_addr 0x4, mem_be 1100, mem_wdata 0xBEEF_BEEF.
  - resp_rdata 0.
- Misaligned load word at 0x1001: resp_valid next cycle with exc 1, code 4, mem_req never high. Store op 011: code 10.
- MAX_WAIT=4, mem_gnt tied 0:
  - mem_req high for 4 cycles, then resp exc code 7.
  - A later stray rvalid is ignored.
- reset pulled low in WAIT:
  - Outputs zero immediately, and no resp_valid follows.
  - The next request completes normally.
